// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch block.
package instr_fetch_pkg;

  // Width of one instruction word returned by the ROM.
  localparam int unsigned INSTR_W = 32;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush. The head word comes straight from the storage
// registers, so there is no combinational path from wdata_i to rdata_o.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 39,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (pop_i && !push_i) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the combinational ROM and queues {pc, instr}
// pairs for decode. Execute redirects flush the queue and reload the PC.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 7,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_en_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  output logic               rom_en_o,
  input  logic [INSTR_W-1:0] rom_data_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_entry_t      wr_entry, rd_entry;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic              pop, push, space;
  logic              unused_bits;

  // Handshake decode: a redirect suppresses both pop and push in its cycle. A full buffer
  // still accepts a fetch when the head leaves in the same cycle.
  always_comb begin
    pop   = !fifo_empty && out_ready_i && !redirect_valid_i;
    space = !fifo_full || pop;
    push  = rst_ni && fetch_en_i && !redirect_valid_i && space;
  end

  // PC next-state: redirect target is word-aligned, otherwise advance on each fetch.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_INC);
    end
  end

  // PC register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = rom_data_i;

  fetch_fifo #(
    .Depth (DEPTH),
    .Width ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rom_addr_o  = pc_q;
  assign rom_en_o    = push;
  assign out_valid_o = !fifo_empty;
  assign out_pc_o    = rd_entry.pc;
  assign out_instr_o = rd_entry.instr;

  // Occupancy is tracked via full/empty; redirect low bits are dropped by alignment.
  assign unused_bits = ^{fifo_count, redirect_pc_i[1:0]};

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model, a per-cycle compare process,
// directed scenarios with literal expectations, then a randomized run.
module tb_instr_fetch;

  localparam int AW    = 7;
  localparam int DEPTH = 2;

  logic          clk;
  logic          rst_n = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rom_addr, out_pc;
  logic          rom_en, out_valid;
  logic [31:0]   rom_data, out_instr;
  logic [31:0]   rom_mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: next fetch address and the queue of undelivered entries.
  int          m_pc = 0;
  int          q_pc [$];
  logic [31:0] q_instr [$];

  instr_fetch #(
    .ADDR_W   (AW),
    .RESET_PC (7'd0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .fetch_en_i       (fetch_en),
    .rom_addr_o       (rom_addr),
    .rom_en_o         (rom_en),
    .rom_data_i       (rom_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc)
  );

  // Combinational ROM.
  assign rom_data = rom_mem[rom_addr[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pop();
    return (q_pc.size() != 0) && out_ready && !redirect_valid;
  endfunction

  function automatic bit m_fetch();
    return fetch_en && !redirect_valid && ((q_pc.size() < DEPTH) || m_pop());
  endfunction

  // Reference model advances on each clock edge and clears on async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0;
      q_pc.delete();
      q_instr.delete();
    end else if (redirect_valid) begin
      q_pc.delete();
      q_instr.delete();
      m_pc = int'(redirect_pc) & 'h7C;
    end else begin
      bit do_pop, do_fetch;
      do_pop   = m_pop();
      do_fetch = m_fetch();
      if (do_pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (do_fetch) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(rom_mem[m_pc / 4]);
        m_pc = (m_pc + 4) % 128;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset rom_en", 32'(rom_en), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
    end else begin
      check("rom_addr", 32'(rom_addr), 32'(m_pc));
      check("rom_en", 32'(rom_en), 32'(m_fetch()));
      check("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
        check("out_pc", 32'(out_pc), 32'(q_pc[0]));
        check("out_instr", out_instr, q_instr[0]);
      end
    end
  end

  // Leaves the caller just after a rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse entirely between two rising edges; call right after cyc().
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst rom_en", 32'(rom_en), 32'd0);
    #5;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int exp_wrap [4];
    int ready_pct;
    exp_wrap = '{120, 124, 0, 4};

    rom_mem[0] = 32'h0000_0013;
    rom_mem[1] = 32'h00F0_0393;
    rom_mem[2] = 32'h0034_8093;
    rom_mem[3] = 32'h4070_8FB3;
    for (int i = 4; i < 32; i++) rom_mem[i] = 32'hA000_0000 | 32'(i);

    // Reset and steady-state streaming.
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;
    #1;
    check("post-reset out_valid", 32'(out_valid), 32'd0);
    check("post-reset out_pc", 32'(out_pc), 32'd0);
    check("post-reset out_instr", out_instr, 32'd0);
    check("post-reset rom_addr", 32'(rom_addr), 32'd0);
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("stream rom_en", 32'(rom_en), 32'd1);
    cyc(); #3;
    check("stream rom_addr 4", 32'(rom_addr), 32'd4);
    check("stream pc0", 32'(out_pc), 32'd0);
    check("stream instr0", out_instr, 32'h0000_0013);
    cyc(); #3;
    check("stream rom_addr 8", 32'(rom_addr), 32'd8);
    check("stream pc4", 32'(out_pc), 32'd4);
    check("stream instr4", out_instr, 32'h00F0_0393);
    cyc(); #3;
    check("stream pc8", 32'(out_pc), 32'd8);
    check("stream instr8", out_instr, 32'h0034_8093);
    cyc(); #3;
    check("stream pc12", 32'(out_pc), 32'd12);
    check("stream instr12", out_instr, 32'h4070_8FB3);
    check("stream valid", 32'(out_valid), 32'd1);

    // Backpressure: two fetches fill the buffer, then hold.
    cyc();
    do_reset();
    out_ready = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      #3;
      check("stall rom_en", 32'(rom_en), 32'd0);
      check("stall rom_addr", 32'(rom_addr), 32'd8);
      check("stall out_pc", 32'(out_pc), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    #3;
    check("release rom_en", 32'(rom_en), 32'd1);
    check("release pc0", 32'(out_pc), 32'd0);
    cyc(); #3;
    check("release pc4", 32'(out_pc), 32'd4);
    cyc(); #3;
    check("release pc8", 32'(out_pc), 32'd8);

    // Redirect while full to a misaligned target.
    cyc();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 7'h0E;
    #3;
    check("redirect rom_en", 32'(rom_en), 32'd0);
    cyc();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #3;
    check("redirect flushed", 32'(out_valid), 32'd0);
    check("redirect rom_addr", 32'(rom_addr), 32'd12);
    cyc(); #3;
    check("redirect first pc", 32'(out_pc), 32'd12);
    check("redirect first instr", out_instr, 32'h4070_8FB3);

    // PC wrap-around.
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 7'd120;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #3;
      check("wrap out_pc", 32'(out_pc), 32'(exp_wrap[i]));
    end

    // Async reset mid-stream.
    cyc();
    check("pre-reset valid", 32'(out_valid), 32'd1);
    do_reset();
    check("after reset rom_addr", 32'(rom_addr), 32'd0);
    check("after reset rom_en", 32'(rom_en), 32'd1);

    // fetch_en toggled 1,0,1.
    cyc();
    fetch_en = 1'b0;
    #3;
    check("fe off rom_addr", 32'(rom_addr), 32'd4);
    check("fe off rom_en", 32'(rom_en), 32'd0);
    check("fe off out_pc", 32'(out_pc), 32'd0);
    cyc();
    fetch_en = 1'b1;
    #3;
    check("fe off valid drop", 32'(out_valid), 32'd0);
    check("fe on rom_addr", 32'(rom_addr), 32'd4);
    cyc(); #3;
    check("fe on out_pc", 32'(out_pc), 32'd4);

    // Randomized run against the model.
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(199) == 0) do_reset();
      ready_pct      = (i / 200) % 3 == 0 ? 20 : ((i / 200) % 3 == 1 ? 60 : 95);
      fetch_en       = $urandom_range(99) < 80;
      out_ready      = $urandom_range(99) < ready_pct;
      redirect_valid = $urandom_range(19) == 0;
      redirect_pc    = AW'($urandom);
    end
    cyc();
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Initiator side of the instruction ROM interface: owns the program counter and drives ROM address/enable.
- Captures returned instruction words into a small buffer.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Sits between the instruction ROM and the decode stage; supports stalls from decode and branch/jump redirects from execute.

Parameters:
- ADDR_W, 7, width of ROM byte address and PC (128-byte ROM space).
- RESET_PC, 0, PC value loaded at reset; must be a multiple of 4.
- DEPTH, 2, entries in the {pc, instr} buffer; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC and issue no ROM reads.
- rom_addr  out  ADDR_W  byte address to ROM; always equal to current PC.
- rom_en  out  1  ROM read enable (combinational).
- rom_data  in  32  ROM read data, valid in the same cycle rom_en is high.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDR_W  new fetch target.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  32  instruction at buffer head.
- out_pc  out  ADDR_W  byte address of out_instr.

Behaviour:
- ROM model: combinational read. rom_data for rom_addr is stable in the cycle rom_en=1 and is captured at that cycle's rising edge.
- Reset (async, any time, including mid-fetch or mid-stall):
  - pc=RESET_PC; buffer empty (count=0, pointers 0).
  - out_valid=0, out_instr=0, out_pc=0.
  - rom_en=0 while rst_n=0.
- pop = out_valid & out_ready & ~redirect_valid.
- space = (count < DEPTH) | pop.
- rom_en = fetch_en & ~redirect_valid & space.
- push = rom_en. On push, write {pc, rom_data} at the write pointer, then pc <= pc + 4.
- PC arithmetic is modulo 2^ADDR_W: with ADDR_W=7, pc=124 advances to 0. No overflow flag.
- count update: push & ~pop increments; pop & ~push decrements; both or neither holds. Push and pop in the same cycle are allowed when full.
- out_valid = (count != 0). out_instr/out_pc come from the buffer head; they are registered outputs with no combinational path from rom_data.
- Redirect has priority over everything:
  - Buffer flushed (count=0) and pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are discarded.
  - No push and no pop in the redirect cycle, even if out_ready=1.
  - First fetch from the new PC occurs the next cycle; its out_valid rises one cycle after that.
- Latency: fetch at cycle N is visible as out_valid at N+1. Steady state with out_ready=1 gives 1 instruction/cycle.
- fetch_en=0: pc holds, no push. Already-buffered entries still drain on out_ready.
- out_ready=0 with buffer full: rom_en=0, pc holds. The head stays stable until accepted (out_instr/out_pc must not change while out_valid=1 and out_ready=0).
- Fetch order equals delivery order. Each address is delivered exactly once between redirects.

Decomposition:
- Shared package holds INSTR_W=32, PC_INC=4, and the fetch-entry struct {pc, instr}.
- One natural sub-module: fetch_fifo, a DEPTH-entry synchronous FIFO with async active-low reset, flush, push/pop, count, full/empty. The PC register and control logic stay in instr_fetch.

Test Plan:
- Reset then fetch_en=1, out_ready=1, ROM {4:0x00F00393, 8:0x00348093, 12:0x40708FB3}:
  - rom_addr sequence 0,4,8,12 on consecutive cycles.
  - out_pc/out_instr 4/0x00F00393, 8/0x00348093, 12/0x40708FB3 one cycle later, out_valid continuously 1.
- Backpressure: hold out_ready=0 for 5 cycles after 2 fetches:
  - count=2, rom_en=0, rom_addr frozen at 8.
  - out_pc=0 stable.
  - Release out_ready: pc 0,4,8 delivered with no duplicates or gaps.
- Redirect while full, redirect_pc=0x0E: buffer flushed, out_valid=0 next cycle; next fetch at 12, first delivered out_pc=12.
- Wrap-around: redirect to 120, run freely: out_pc sequence 120,124,0,4.
- Async reset asserted mid-stream between clock edges: out_valid drops immediately, rom_en=0. After release, the first rom_addr is RESET_PC.
- fetch_en toggled 1,0,1 with out_ready=1: pc holds during the off cycle, out_valid drops one cycle later, order preserved.
